// File: rtl/requantize_pkg.sv
// Shared constants for the requantiser: rounding-mode encodings and the
// width of the saturation debug counter.
package requantize_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'd0;
    localparam logic [1:0] RND_HALF_UP   = 2'd1;
    localparam logic [1:0] RND_HALF_EVEN = 2'd2;
    localparam logic [1:0] RND_HALF_AWAY = 2'd3;

    localparam int SAT_W = 16;

endpackage

// File: rtl/requantize_pipe_if.sv
// Streaming, configuration and debug signals of the requantiser.
// The master drives beats and configuration; the slave is the requantiser.
interface requantize_pipe_if
    import requantize_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) ();

    logic                      cfg_we;
    logic signed [SHIFT_W-1:0] cfg_shift;
    logic [1:0]                cfg_round;
    logic signed [OUT_W-1:0]   cfg_zero_point;
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_W*SIZE-1:0]      pixel_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W*SIZE-1:0]     pixel_out;
    logic                      sat_clear;
    logic [SAT_W-1:0]          sat_count;

    modport master (
        output cfg_we, cfg_shift, cfg_round, cfg_zero_point,
        output in_valid, pixel_in, out_ready, sat_clear,
        input  in_ready, out_valid, pixel_out, sat_count
    );

    modport slave (
        input  cfg_we, cfg_shift, cfg_round, cfg_zero_point,
        input  in_valid, pixel_in, out_ready, sat_clear,
        output in_ready, out_valid, pixel_out, sat_count
    );

endinterface

// File: rtl/requantize_lane.sv
// One requantiser lane: signed shift with rounding on right shifts,
// zero-point offset and clip to the signed output range.
module requantize_lane
    import requantize_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic signed [IN_W-1:0]    din,
    input  logic signed [SHIFT_W-1:0] shift,
    input  logic [1:0]                rnd,
    input  logic signed [OUT_W-1:0]   zp,
    output logic signed [OUT_W-1:0]   dout,
    output logic                      clipped
);

    // Wide enough that neither the largest left shift nor the rounding bias can overflow
    localparam int EXT_W = IN_W + 2**(SHIFT_W-1);

    localparam logic signed [EXT_W-1:0] ONE_EXT  = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic signed [EXT_W-1:0] ZERO_EXT = {EXT_W{1'b0}};
    localparam logic [SHIFT_W:0]        RSH_ONE  = {{SHIFT_W{1'b0}}, 1'b1};
    localparam logic signed [EXT_W-1:0] OUT_MAX  = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN  = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] ext_s;
    logic signed [EXT_W-1:0] half_s;
    logic signed [EXT_W-1:0] rem_s;
    logic signed [EXT_W-1:0] trunc_s;
    logic signed [EXT_W-1:0] shifted_s;
    logic signed [EXT_W-1:0] sum_s;
    logic [SHIFT_W:0]        rsh_s;

    // Shift/round, then offset and clip
    always_comb begin
        ext_s   = {{(EXT_W-IN_W){din[IN_W-1]}}, din};
        rsh_s   = -{shift[SHIFT_W-1], shift};
        half_s  = ONE_EXT <<< (rsh_s - RSH_ONE);
        rem_s   = ext_s & ((half_s <<< 1) - ONE_EXT);
        trunc_s = ext_s >>> rsh_s;
        if (!shift[SHIFT_W-1]) begin
            shifted_s = ext_s <<< shift[SHIFT_W-2:0];
        end else begin
            case (rnd)
                RND_TRUNC:     shifted_s = trunc_s;
                RND_HALF_UP:   shifted_s = (ext_s + half_s) >>> rsh_s;
                RND_HALF_EVEN: begin
                    if (rem_s > half_s) begin
                        shifted_s = trunc_s + ONE_EXT;
                    end else if (rem_s == half_s) begin
                        shifted_s = trunc_s + (trunc_s[0] ? ONE_EXT : ZERO_EXT);
                    end else begin
                        shifted_s = trunc_s;
                    end
                end
                RND_HALF_AWAY: begin
                    if (ext_s[EXT_W-1]) begin
                        shifted_s = (ext_s + half_s - ONE_EXT) >>> rsh_s;
                    end else begin
                        shifted_s = (ext_s + half_s) >>> rsh_s;
                    end
                end
                default:       shifted_s = trunc_s;
            endcase
        end
        sum_s = shifted_s + {{(EXT_W-OUT_W){zp[OUT_W-1]}}, zp};
        if (sum_s > OUT_MAX) begin
            dout    = OUT_MAX[OUT_W-1:0];
            clipped = 1'b1;
        end else if (sum_s < OUT_MIN) begin
            dout    = OUT_MIN[OUT_W-1:0];
            clipped = 1'b1;
        end else begin
            dout    = sum_s[OUT_W-1:0];
            clipped = 1'b0;
        end
    end

endmodule

// File: rtl/requantize_pipe.sv
// Two-stage requantiser: stage 1 captures a beat with its own configuration,
// stage 2 registers the lane results and counts clipped lanes.
module requantize_pipe
    import requantize_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    requantize_pipe_if.slave bus
);

    localparam int CNT_W = $clog2(SIZE + 1) + 1;

    logic signed [SHIFT_W-1:0] cfg_shift_r;
    logic [1:0]                cfg_round_r;
    logic signed [OUT_W-1:0]   cfg_zp_r;

    logic                      s1_valid_r;
    logic [IN_W*SIZE-1:0]      s1_pixel_r;
    logic signed [SHIFT_W-1:0] s1_shift_r;
    logic [1:0]                s1_round_r;
    logic signed [OUT_W-1:0]   s1_zp_r;

    logic                      out_valid_r;
    logic [OUT_W*SIZE-1:0]     pixel_out_r;
    logic [SAT_W-1:0]          sat_count_r;

    logic                      s1_advance_s;
    logic                      in_ready_s;
    logic                      in_fire_s;
    logic [OUT_W*SIZE-1:0]     lane_out_s;
    logic [SIZE-1:0]           clipped_s;
    logic [CNT_W-1:0]          clip_cnt_s;
    logic [SAT_W:0]            sat_sum_s;
    logic [SAT_W-1:0]          sat_next_s;

    assign s1_advance_s = s1_valid_r & (~out_valid_r | bus.out_ready);
    assign in_ready_s   = ~s1_valid_r | s1_advance_s;
    assign in_fire_s    = bus.in_valid & in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.pixel_out = pixel_out_r;
    assign bus.sat_count = sat_count_r;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        requantize_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .din     (s1_pixel_r[IN_W*i +: IN_W]),
            .shift   (s1_shift_r),
            .rnd     (s1_round_r),
            .zp      (s1_zp_r),
            .dout    (lane_out_s[OUT_W*i +: OUT_W]),
            .clipped (clipped_s[i])
        );
    end

    // Clipped-lane population count and saturating counter increment
    always_comb begin
        clip_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            clip_cnt_s = clip_cnt_s + {{(CNT_W-1){1'b0}}, clipped_s[i]};
        end
        sat_sum_s = {1'b0, sat_count_r} + (SAT_W+1)'(clip_cnt_s);
        if (sat_sum_s[SAT_W]) begin
            sat_next_s = {SAT_W{1'b1}};
        end else begin
            sat_next_s = sat_sum_s[SAT_W-1:0];
        end
    end

    // Configuration registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_shift_r <= {SHIFT_W{1'b0}};
            cfg_round_r <= 2'd0;
            cfg_zp_r    <= {OUT_W{1'b0}};
        end else if (bus.cfg_we) begin
            cfg_shift_r <= bus.cfg_shift;
            cfg_round_r <= bus.cfg_round;
            cfg_zp_r    <= bus.cfg_zero_point;
        end
    end

    // Stage 1: beat plus the configuration in force when it was accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_pixel_r <= {(IN_W*SIZE){1'b0}};
            s1_shift_r <= {SHIFT_W{1'b0}};
            s1_round_r <= 2'd0;
            s1_zp_r    <= {OUT_W{1'b0}};
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_pixel_r <= bus.pixel_in;
            s1_shift_r <= cfg_shift_r;
            s1_round_r <= cfg_round_r;
            s1_zp_r    <= cfg_zp_r;
        end else if (s1_advance_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: output register, held while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            pixel_out_r <= {(OUT_W*SIZE){1'b0}};
        end else if (s1_advance_s) begin
            out_valid_r <= 1'b1;
            pixel_out_r <= lane_out_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky saturation counter; clear beats a simultaneous increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_count_r <= {SAT_W{1'b0}};
        end else if (bus.sat_clear) begin
            sat_count_r <= {SAT_W{1'b0}};
        end else if (s1_advance_s) begin
            sat_count_r <= sat_next_s;
        end
    end

endmodule

// File: tb/tb_requantize_pipe.sv
// Directed bench for requantize_pipe: rounding, saturation, zero point,
// backpressure, mid-stream reconfiguration and asynchronous reset.
module tb_requantize_pipe;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    requantize_pipe_if #(.SIZE(4), .IN_W(32), .OUT_W(8), .SHIFT_W(6)) bus ();

    requantize_pipe #(.SIZE(4), .IN_W(32), .OUT_W(8), .SHIFT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [127:0] pack32(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Called #1 after a rising edge; returns #1 after the write edge
    task automatic set_cfg(input int s, input int r, input int z);
        bus.cfg_we = 1'b1;
        bus.cfg_shift = s[5:0];
        bus.cfg_round = r[1:0];
        bus.cfg_zero_point = z[7:0];
        @(posedge clock); #1;
        bus.cfg_we = 1'b0;
    endtask

    // One beat with out_ready high; reports acceptance, the early valid and the valid/data two cycles later
    task automatic xfer(input logic [127:0] p, output logic acc, output logic v_early,
                        output logic v_lat, output logic [31:0] dout);
        bus.in_valid = 1'b1;
        bus.pixel_in = p;
        acc = bus.in_ready;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        v_early = bus.out_valid;
        @(posedge clock); #1;
        v_lat = bus.out_valid;
        dout = bus.pixel_out;
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.pixel_out !== 32'h0) begin errors++; $display("FAIL reset_pixel_out: got %h expected 00000000", bus.pixel_out); end
        checks++; if (bus.sat_count !== 16'h0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", bus.sat_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_rounding();
        logic [31:0] exp_tab [4];
        logic acc, ve, vl;
        logic [31:0] d;
        exp_tab[0] = pack8(1, 2, -3, 1);
        exp_tab[1] = pack8(2, 3, -2, 1);
        exp_tab[2] = pack8(2, 2, -2, 1);
        exp_tab[3] = pack8(2, 3, -3, 1);
        for (int m = 0; m < 4; m++) begin
            set_cfg(-4, m, 0);
            xfer(pack32(24, 40, -40, 23), acc, ve, vl, d);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL round%0d_accept: in_ready got %b expected 1", m, acc); end
            checks++; if (ve !== 1'b0) begin errors++; $display("FAIL round%0d_early_valid: got %b expected 0", m, ve); end
            checks++; if (vl !== 1'b1) begin errors++; $display("FAIL round%0d_latency_valid: got %b expected 1", m, vl); end
            checks++; if (d !== exp_tab[m]) begin errors++; $display("FAIL round%0d_data: got %h expected %h", m, d, exp_tab[m]); end
        end
        checks++; if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL round_sat_count: got %0d expected 0", bus.sat_count); end
    endtask

    task automatic test_saturation();
        logic acc, ve, vl;
        logic [31:0] d;
        set_cfg(4, 0, 0);
        xfer(pack32(16, -300, 0, 0), acc, ve, vl, d);
        checks++; if (d !== pack8(127, -128, 0, 0)) begin errors++; $display("FAIL sat_data: got %h expected %h", d, pack8(127, -128, 0, 0)); end
        checks++; if (bus.sat_count !== 16'd2) begin errors++; $display("FAIL sat_count_two: got %0d expected 2", bus.sat_count); end
        bus.in_valid = 1'b1;
        bus.pixel_in = pack32(16, 0, 0, 0);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.sat_clear = 1'b1;
        @(posedge clock); #1;
        bus.sat_clear = 1'b0;
        checks++; if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_clear_wins: got %0d expected 0", bus.sat_count); end
        checks++; if (bus.pixel_out !== pack8(127, 0, 0, 0)) begin errors++; $display("FAIL sat_clear_data: got %h expected %h", bus.pixel_out, pack8(127, 0, 0, 0)); end
    endtask

    task automatic test_zero_point();
        logic acc, ve, vl;
        logic [31:0] d;
        set_cfg(0, 0, 20);
        xfer(pack32(100, 120, 0, 0), acc, ve, vl, d);
        checks++; if (d !== pack8(120, 127, 20, 20)) begin errors++; $display("FAIL zp_data: got %h expected %h", d, pack8(120, 127, 20, 20)); end
        checks++; if (bus.sat_count !== 16'd1) begin errors++; $display("FAIL zp_sat_count: got %0d expected 1", bus.sat_count); end
    endtask

    task automatic test_back_to_back();
        set_cfg(0, 0, 0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.pixel_in = pack32(1, 2, 3, 4);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", bus.in_ready); end
        @(posedge clock); #1;
        bus.pixel_in = pack32(5, 6, 7, 8);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b expected 1", bus.in_ready); end
        @(posedge clock); #1;
        bus.pixel_in = pack32(9, 10, 11, 12);
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low%0d: got %b expected 0", c, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held%0d: got %b expected 1", c, bus.out_valid); end
            checks++; if (bus.pixel_out !== pack8(1, 2, 3, 4)) begin errors++; $display("FAIL bp_stable%0d: got %h expected %h", c, bus.pixel_out, pack8(1, 2, 3, 4)); end
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", bus.in_ready); end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.pixel_out !== pack8(5, 6, 7, 8)) begin errors++; $display("FAIL bp_beat_b: got %b/%h expected 1/%h", bus.out_valid, bus.pixel_out, pack8(5, 6, 7, 8)); end
        @(posedge clock); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.pixel_out !== pack8(9, 10, 11, 12)) begin errors++; $display("FAIL bp_beat_c: got %b/%h expected 1/%h", bus.out_valid, bus.pixel_out, pack8(9, 10, 11, 12)); end
        @(posedge clock); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reconfig();
        set_cfg(-4, 0, 0);
        bus.in_valid = 1'b1;
        bus.pixel_in = pack32(100, -100, 50, 7);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b1;
        bus.cfg_shift = 6'd0;
        @(posedge clock); #1;
        bus.cfg_we = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.pixel_out !== pack8(6, -7, 3, 0)) begin errors++; $display("FAIL reconfig_beat_a: got %b/%h expected 1/%h", bus.out_valid, bus.pixel_out, pack8(6, -7, 3, 0)); end
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reconfig_gap: got %b expected 0", bus.out_valid); end
        @(posedge clock); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.pixel_out !== pack8(100, -100, 50, 7)) begin errors++; $display("FAIL reconfig_beat_b: got %b/%h expected 1/%h", bus.out_valid, bus.pixel_out, pack8(100, -100, 50, 7)); end
    endtask

    task automatic test_async_reset();
        logic acc, ve, vl;
        logic [31:0] d;
        set_cfg(2, 0, 3);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.pixel_in = pack32(5, 5, 5, 5);
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_setup: valid/ready got %b/%b expected 1/0", bus.out_valid, bus.in_ready); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.pixel_out !== 32'h0) begin errors++; $display("FAIL rst_async_pixel: got %h expected 00000000", bus.pixel_out); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL rst_async_sat: got %0d expected 0", bus.sat_count); end
        #2;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        xfer(pack32(5, -5, 0, 1), acc, ve, vl, d);
        checks++; if (vl !== 1'b1 || d !== pack8(5, -5, 0, 1)) begin errors++; $display("FAIL rst_cfg_cleared: got %b/%h expected 1/%h", vl, d, pack8(5, -5, 0, 1)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.cfg_we = 1'b0;
        bus.cfg_shift = 6'd0;
        bus.cfg_round = 2'd0;
        bus.cfg_zero_point = 8'd0;
        bus.in_valid = 1'b0;
        bus.pixel_in = 128'd0;
        bus.out_ready = 1'b1;
        bus.sat_clear = 1'b0;
        #12;
        reset = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_zero_point();
        test_back_to_back();
        test_reconfig();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
